// File: rtl/risc_mem_pkg.sv
// Shared definitions for the load/store unit: FSM states and default widths.
package risc_mem_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/risc_sat_counter.sv
// Saturating up-counter with asynchronous reset; holds at all-ones.
module risc_sat_counter
    import risc_mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one event per inc pulse, sticking at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/risc_load_store_unit.sv
// Load/store unit: accepts one request from EX, performs a single-cycle
// memory access, then holds the response until WB consumes it.
module risc_load_store_unit
    import risc_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_mw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_we,
    output logic              resp_fault,
    output logic [15:0]       ld_cnt,
    output logic [15:0]       st_cnt
);

    lsu_state_t        state;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [4:0]        op_rd;
    logic              in_range;
    logic              done;
    logic              ld_inc;
    logic              st_inc;

    // Extra top bit keeps the compare correct even when MEM_DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, op_addr} < (ADDR_W + 1)'(MEM_DEPTH));

    // Strobe is decoded from state so an async reset drops it at once.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_mw     = (state == ACCESS) && op_we && in_range;
    assign mem_addr   = op_addr;
    assign mem_wdata  = op_wdata;

    // Counters only advance on the WB handshake of a non-faulting response.
    assign done   = (state == RESP) && resp_ready && !resp_fault;
    assign ld_inc = done && !resp_we;
    assign st_inc = done && resp_we;

    // Request/response sequencing: IDLE -> ACCESS -> RESP -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= '0;
            op_rd      <= '0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_we    <= 1'b0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we    <= req_we;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                        op_rd    <= req_rd;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_rdata <= (!op_we && in_range) ? mem_rdata : '0;
                    resp_fault <= !in_range;
                    resp_we    <= op_we;
                    resp_rd    <= op_rd;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    risc_sat_counter #(.W(CNT_W)) u_ld_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ld_inc),
        .count (ld_cnt)
    );

    risc_sat_counter #(.W(CNT_W)) u_st_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (st_inc),
        .count (st_cnt)
    );

endmodule

// File: tb/tb_risc_load_store_unit.sv
// Directed bench for risc_load_store_unit with a behavioural data memory.
module tb_risc_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_mw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_we;
    logic        resp_fault;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mw_cycles = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    risc_load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_mw     (mem_mw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_we    (resp_we),
        .resp_fault (resp_fault),
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
    );

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_mw && (mem_addr < 32'd1024)) mem[mem_addr[9:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_mw) mw_cycles = mw_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request and return at the negedge just after it is accepted.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_rd = rd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Complete the handshake from the RESP negedge; returns at the next negedge.
    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        int mw0;
        logic [31:0] snap_rdata;
        logic [4:0]  snap_rd;
        logic [31:0] addrs [3];
        int acc [3];
        int rcyc [3];
        logic [31:0] rdat [3];
        int k, nr;
        logic go;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + i;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_mw", 64'(mem_mw), 64'd0);
        check("rst_counts", {32'd0, ld_cnt, st_cnt}, 64'd0);
        reset = 1'b0;
        check("rel_req_ready", 64'(req_ready), 64'd1);

        // Store 5 then load 5
        mw0 = mw_cycles;
        issue(1'b1, 32'd5, 32'hDEADBEEF, 5'd3);
        check("st_mw", 64'(mem_mw), 64'd1);
        check("st_mem_addr", 64'(mem_addr), 64'd5);
        check("st_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        check("st_ready_busy", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("st_resp_valid", 64'(resp_valid), 64'd1);
        check("st_resp_rdata", 64'(resp_rdata), 64'd0);
        check("st_resp_flags", {62'd0, resp_we, resp_fault}, 64'b10);
        check("st_mw_off", 64'(mem_mw), 64'd0);
        take_resp();
        check("st_mw_cycles", 64'(mw_cycles - mw0), 64'd1);
        check("st_mem5", 64'(mem[5]), 64'hDEADBEEF);
        check("st_cnt1", 64'(st_cnt), 64'd1);
        check("st_idle", 64'(req_ready), 64'd1);

        issue(1'b0, 32'd5, 32'h0, 5'd9);
        check("ld_mw", 64'(mem_mw), 64'd0);
        @(negedge clk);
        check("ld_rdata", 64'(resp_rdata), 64'hDEADBEEF);
        check("ld_rd", 64'(resp_rd), 64'd9);
        check("ld_flags", {62'd0, resp_we, resp_fault}, 64'b00);
        take_resp();
        check("ld_cnts", {32'd0, ld_cnt, st_cnt}, {32'd0, 16'd1, 16'd1});

        // Out-of-range store and load
        mw0 = mw_cycles;
        issue(1'b1, 32'd1024, 32'h12345678, 5'd1);
        check("oor_st_mw", 64'(mem_mw), 64'd0);
        @(negedge clk);
        check("oor_st_fault", 64'(resp_fault), 64'd1);
        check("oor_st_rdata", 64'(resp_rdata), 64'd0);
        take_resp();
        check("oor_st_mw_cycles", 64'(mw_cycles - mw0), 64'd0);
        check("oor_st_cnt", 64'(st_cnt), 64'd1);
        issue(1'b0, 32'd2000, 32'h0, 5'd2);
        @(negedge clk);
        check("oor_ld_fault", 64'(resp_fault), 64'd1);
        check("oor_ld_rdata", 64'(resp_rdata), 64'd0);
        take_resp();
        check("oor_ld_cnt", 64'(ld_cnt), 64'd1);

        // Backpressure with a competing request held on the input
        mw0 = mw_cycles;
        issue(1'b0, 32'd1, 32'h0, 5'd4);
        @(negedge clk);
        snap_rdata = resp_rdata; snap_rd = resp_rd;
        check("bp_rdata", 64'(snap_rdata), 64'hA5000001);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd6; req_wdata = 32'h55; req_rd = 5'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_stable", {27'd0, resp_rd, resp_rdata}, {27'd0, snap_rd, snap_rdata});
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        take_resp();
        check("bp_no_accept_mw", 64'(mw_cycles - mw0), 64'd0);
        check("bp_cnts", {32'd0, ld_cnt, st_cnt}, {32'd0, 16'd2, 16'd1});
        check("bp_mem6", 64'(mem[6]), 64'hA5000006);

        // Reset in the middle of a store access
        issue(1'b1, 32'd7, 32'hCAFEF00D, 5'd8);
        check("mr_mw_before", 64'(mem_mw), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("mr_mw_drop", 64'(mem_mw), 64'd0);
        check("mr_mem_bus", {mem_addr, mem_wdata}, 64'd0);
        check("mr_resp", {resp_valid, resp_rdata, resp_rd, resp_we, resp_fault}, 64'd0);
        check("mr_cnts", {32'd0, ld_cnt, st_cnt}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        check("mr_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("mr_mem7", 64'(mem[7]), 64'hA5000007);
        check("mr_no_resp", 64'(resp_valid), 64'd0);

        // Store counter saturation
        force dut.u_st_cnt.count = 16'hFFFE;
        @(negedge clk);
        release dut.u_st_cnt.count;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 32'd10 + i, 32'h100 + i, 5'd1);
            @(negedge clk);
            take_resp();
            check("sat_st_cnt", 64'(st_cnt), 64'hFFFF);
        end
        check("sat_ld_cnt", 64'(ld_cnt), 64'd0);

        // Back-to-back loads with resp_ready held high
        addrs[0] = 32'd0; addrs[1] = 32'd1; addrs[2] = 32'd1023;
        k = 0; nr = 0;
        @(negedge clk);
        req_we = 1'b0; req_addr = addrs[0]; req_rd = 5'd20; req_valid = 1'b1; resp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (resp_valid && nr < 3) begin
                rcyc[nr] = cyc; rdat[nr] = resp_rdata; nr++;
            end
            go = 1'b0;
            if (req_valid && req_ready && k < 3) begin
                acc[k] = cyc + 1; k++; go = 1'b1;
            end
            @(negedge clk);
            if (go) begin
                if (k < 3) begin
                    req_addr = addrs[k]; req_rd = 5'(20 + k);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        resp_ready = 1'b0;
        check("tp_accepts", 64'(k), 64'd3);
        check("tp_resps", 64'(nr), 64'd3);
        if (k == 3 && nr == 3) begin
            check("tp_gap01", 64'(acc[1] - acc[0]), 64'd3);
            check("tp_gap12", 64'(acc[2] - acc[1]), 64'd3);
            for (int i = 0; i < 3; i++) begin
                check("tp_resp_time", 64'(rcyc[i] + 1), 64'(acc[i] + 2));
            end
            check("tp_rdata0", 64'(rdat[0]), 64'hA5000000);
            check("tp_rdata1", 64'(rdat[1]), 64'hA5000001);
            check("tp_rdata2", 64'(rdat[2]), 64'hA50003FF);
        end
        check("tp_ld_cnt", 64'(ld_cnt), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
